// File: rtl/bcd_updown_counter.sv
// Synchronous multi-decade BCD up/down counter with load, clear, terminal count,
// wrap/saturate handling and a rejected-load flag. All decades share one clock.
module bcd_updown_counter #(
    parameter int DIGITS   = 4,
    parameter int SATURATE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   load_val_i,
    input  logic                  en_i,
    input  logic                  up_i,
    output logic [4*DIGITS-1:0]   cnt_o,
    output logic                  tc_o,
    output logic                  wrap_o,
    output logic                  load_err_o
);

    localparam int              W      = 4 * DIGITS;
    localparam bit              SAT_EN = (SATURATE != 0);
    localparam logic [W-1:0]    MAX_C  = {DIGITS{4'd9}};
    localparam logic [W-1:0]    MIN_C  = {W{1'b0}};

    // True when every decade of v holds a legal BCD digit.
    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    // Ripple-free decimal increment; a decade moves only while all lower decades carry.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic         carry;
        logic [W-1:0] r;
        carry = 1'b1;
        r     = v;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (v[4*k +: 4] == 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                r[4*k +: 4] = v[4*k +: 4];
            end
        end
        return r;
    endfunction

    // Decimal decrement; a decade borrows only while all lower decades are zero.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic         borrow;
        logic [W-1:0] r;
        borrow = 1'b1;
        r      = v;
        for (int k = 0; k < DIGITS; k++) begin
            if (borrow) begin
                if (v[4*k +: 4] == 4'd0) begin
                    r[4*k +: 4] = 4'd9;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                r[4*k +: 4] = v[4*k +: 4];
            end
        end
        return r;
    endfunction

    logic [W-1:0] cnt_r;
    logic         wrap_r;
    logic         load_err_r;
    logic [W-1:0] cnt_nxt_s;
    logic         wrap_nxt_s;
    logic         load_err_nxt_s;
    logic         at_max_s;
    logic         at_min_s;

    assign at_max_s = (cnt_r == MAX_C);
    assign at_min_s = (cnt_r == MIN_C);

    // Terminal count looks only at enable/direction and the limits; forced low in reset.
    assign tc_o = rst & en_i & ((up_i & at_max_s) | (~up_i & at_min_s));

    // Next-state selection with priority clear > load > count > hold.
    always_comb begin
        cnt_nxt_s      = cnt_r;
        wrap_nxt_s     = 1'b0;
        load_err_nxt_s = 1'b0;
        if (clr_i) begin
            cnt_nxt_s = MIN_C;
        end else if (load_i) begin
            if (bcd_valid(load_val_i)) begin
                cnt_nxt_s = load_val_i;
            end else begin
                load_err_nxt_s = 1'b1;
            end
        end else if (en_i) begin
            if (up_i) begin
                if (at_max_s && SAT_EN) begin
                    cnt_nxt_s = cnt_r;
                end else begin
                    cnt_nxt_s  = bcd_inc(cnt_r);
                    wrap_nxt_s = at_max_s;
                end
            end else begin
                if (at_min_s && SAT_EN) begin
                    cnt_nxt_s = cnt_r;
                end else begin
                    cnt_nxt_s  = bcd_dec(cnt_r);
                    wrap_nxt_s = at_min_s;
                end
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count and flag registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r      <= MIN_C;
            wrap_r     <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            cnt_r      <= cnt_nxt_s;
            wrap_r     <= wrap_nxt_s;
            load_err_r <= load_err_nxt_s;
        end
    end

    assign cnt_o      = cnt_r;
    assign wrap_o     = wrap_r;
    assign load_err_o = load_err_r;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed self-checking bench for a 2-decade counter in wrap mode and a
// 2-decade counter in saturate mode driven by the same stimulus.
module tb_bcd_updown_counter;

    logic       clk;
    logic       rst;
    logic       clr_i;
    logic       load_i;
    logic [7:0] load_val_i;
    logic       en_i;
    logic       up_i;
    logic [7:0] cnt_w_s;
    logic       tc_w_s;
    logic       wrap_w_s;
    logic       err_w_s;
    logic [7:0] cnt_s_s;
    logic       tc_s_s;
    logic       wrap_s_s;
    logic       err_s_s;

    int n_total;
    int n_bad;

    bcd_updown_counter #(.DIGITS(2), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .clr_i(clr_i), .load_i(load_i),
        .load_val_i(load_val_i), .en_i(en_i), .up_i(up_i),
        .cnt_o(cnt_w_s), .tc_o(tc_w_s), .wrap_o(wrap_w_s), .load_err_o(err_w_s)
    );

    bcd_updown_counter #(.DIGITS(2), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .clr_i(clr_i), .load_i(load_i),
        .load_val_i(load_val_i), .en_i(en_i), .up_i(up_i),
        .cnt_o(cnt_s_s), .tc_o(tc_s_s), .wrap_o(wrap_s_s), .load_err_o(err_s_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_v;
        n_total    = 0;
        n_bad      = 0;
        rst        = 1'b0;
        clr_i      = 1'b0;
        load_i     = 1'b0;
        load_val_i = 8'h00;
        en_i       = 1'b1;
        up_i       = 1'b0;
        #12;
        // In reset with en=1, up=0 and cnt=MIN: tc must still be low.
        chk("rst_cnt",  {24'd0, cnt_w_s}, 32'h00);
        chk("rst_wrap", {31'd0, wrap_w_s}, 32'd0);
        chk("rst_err",  {31'd0, err_w_s}, 32'd0);
        chk("rst_tc",   {31'd0, tc_w_s}, 32'd0);
        en_i = 1'b0;
        @(negedge clk);
        rst  = 1'b1;
        #1;
        chk("post_rel_cnt", {24'd0, cnt_w_s}, 32'h00);

        // Count up through every value 01..99.
        en_i = 1'b1;
        up_i = 1'b1;
        for (int i = 1; i < 100; i++) begin
            tick();
            exp_v = {4'(i / 10), 4'(i % 10)};
            chk("up_cnt", {24'd0, cnt_w_s}, {24'd0, exp_v});
            chk("up_tc", {31'd0, tc_w_s}, {31'd0, (i == 99)});
        end
        chk("up_wrap_pre", {31'd0, wrap_w_s}, 32'd0);
        tick();
        chk("wrap_cnt",  {24'd0, cnt_w_s}, 32'h00);
        chk("wrap_flag", {31'd0, wrap_w_s}, 32'd1);
        chk("sat_hold_cnt",  {24'd0, cnt_s_s}, 32'h99);
        chk("sat_hold_wrap", {31'd0, wrap_s_s}, 32'd0);
        tick();
        chk("wrap_cnt2",  {24'd0, cnt_w_s}, 32'h01);
        chk("wrap_flag2", {31'd0, wrap_w_s}, 32'd0);

        // Down count with borrow, load of 10 first.
        en_i       = 1'b0;
        load_i     = 1'b1;
        load_val_i = 8'h10;
        tick();
        load_i = 1'b0;
        chk("ld10", {24'd0, cnt_w_s}, 32'h10);
        en_i = 1'b1;
        up_i = 1'b0;
        tick();
        chk("dn09", {24'd0, cnt_w_s}, 32'h09);
        tick();
        chk("dn08", {24'd0, cnt_w_s}, 32'h08);
        load_i     = 1'b1;
        load_val_i = 8'h01;
        tick();
        load_i = 1'b0;
        chk("ld_no_count", {24'd0, cnt_w_s}, 32'h01);
        tick();
        chk("dn00", {24'd0, cnt_w_s}, 32'h00);
        chk("tc_min_down", {31'd0, tc_w_s}, 32'd1);
        up_i = 1'b1;
        #1;
        chk("tc_min_up", {31'd0, tc_w_s}, 32'd0);
        up_i = 1'b0;
        tick();
        chk("dn_wrap_cnt",  {24'd0, cnt_w_s}, 32'h99);
        chk("dn_wrap_flag", {31'd0, wrap_w_s}, 32'd1);

        // Illegal load is rejected with a one-cycle error pulse.
        en_i       = 1'b0;
        load_i     = 1'b1;
        load_val_i = 8'h42;
        tick();
        chk("ld42", {24'd0, cnt_w_s}, 32'h42);
        chk("ld42_err", {31'd0, err_w_s}, 32'd0);
        load_val_i = 8'h3A;
        tick();
        chk("ld3a_cnt", {24'd0, cnt_w_s}, 32'h42);
        chk("ld3a_err", {31'd0, err_w_s}, 32'd1);
        load_val_i = 8'h37;
        tick();
        chk("ld37_cnt", {24'd0, cnt_w_s}, 32'h37);
        chk("ld37_err", {31'd0, err_w_s}, 32'd0);
        load_val_i = 8'hA1;
        tick();
        load_i = 1'b0;
        chk("lda1_cnt", {24'd0, cnt_w_s}, 32'h37);
        chk("lda1_err", {31'd0, err_w_s}, 32'd1);
        tick();
        chk("err_clear", {31'd0, err_w_s}, 32'd0);

        // Priority: clear beats load and enable; load beats enable.
        clr_i      = 1'b1;
        load_i     = 1'b1;
        load_val_i = 8'h55;
        en_i       = 1'b1;
        up_i       = 1'b1;
        tick();
        chk("prio_clr", {24'd0, cnt_w_s}, 32'h00);
        chk("prio_clr_wrap", {31'd0, wrap_w_s}, 32'd0);
        clr_i = 1'b0;
        tick();
        chk("prio_ld", {24'd0, cnt_w_s}, 32'h55);
        load_i = 1'b0;
        tick();
        chk("prio_inc", {24'd0, cnt_w_s}, 32'h56);

        // Saturate mode holds at the upper limit.
        en_i       = 1'b0;
        load_i     = 1'b1;
        load_val_i = 8'h98;
        tick();
        load_i = 1'b0;
        en_i   = 1'b1;
        up_i   = 1'b1;
        tick();
        chk("sat99a", {24'd0, cnt_s_s}, 32'h99);
        chk("sat_tc", {31'd0, tc_s_s}, 32'd1);
        tick();
        chk("sat99b", {24'd0, cnt_s_s}, 32'h99);
        chk("sat_wrap_b", {31'd0, wrap_s_s}, 32'd0);
        chk("wrapmode_00", {24'd0, cnt_w_s}, 32'h00);
        tick();
        chk("sat99c", {24'd0, cnt_s_s}, 32'h99);
        chk("sat_wrap_c", {31'd0, wrap_s_s}, 32'd0);
        up_i = 1'b0;
        tick();
        chk("sat98", {24'd0, cnt_s_s}, 32'h98);

        // Asynchronous reset mid-cycle, then resume counting.
        en_i       = 1'b0;
        load_i     = 1'b1;
        load_val_i = 8'h47;
        tick();
        load_i = 1'b0;
        chk("ld47", {24'd0, cnt_w_s}, 32'h47);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst", {24'd0, cnt_w_s}, 32'h00);
        @(negedge clk);
        rst  = 1'b1;
        en_i = 1'b1;
        up_i = 1'b1;
        tick();
        chk("resume01", {24'd0, cnt_w_s}, 32'h01);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
